// File: rtl/paper_pkg.sv
// Shared encodings for the PaperProcessor sequencer: opcodes, FSM states, ALU selects.
package paper_pkg;

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_LDA = 3'd1;
  localparam logic [2:0] OP_STA = 3'd2;
  localparam logic [2:0] OP_ADD = 3'd3;
  localparam logic [2:0] OP_SUB = 3'd4;
  localparam logic [2:0] OP_JMP = 3'd5;
  localparam logic [2:0] OP_JZ  = 3'd6;
  localparam logic [2:0] OP_HLT = 3'd7;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_MEM    = 3'd2,
    ST_WB     = 3'd3,
    ST_EXEC   = 3'd4,
    ST_HALT   = 3'd5,
    ST_PAUSE  = 3'd6
  } state_e;

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;

  function automatic logic [1:0] alu_for(input logic [2:0] op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      default: return ALU_PASS;
    endcase
  endfunction

endpackage

// File: rtl/paper_retire_cnt.sv
// Retired-instruction counter: synchronous clear, wraps at 2^CNTW.
module paper_retire_cnt #(
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inc,
  output logic [CNTW-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (inc)
      cnt <= cnt + CNTW'(1);
  end

endmodule

// File: rtl/paper_seq_ctrl.sv
// Multi-cycle control FSM for the PaperProcessor accumulator datapath.
// Build option: PAPER_STEP_EN adds a step input and a PAUSE state after each retire.
module paper_seq_ctrl
  import paper_pkg::*;
#(
  parameter int OPW  = 4,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
`ifdef PAPER_STEP_EN
  input  logic            step,
`endif
  input  logic [OPW-1:0]  ir_op,
  input  logic            acc_zero,
  input  logic            mem_rdy,
  output logic            pc_en,
  output logic            pc_ld,
  output logic            ir_en,
  output logic            acc_en,
  output logic            acc_sel,
  output logic [1:0]      alu_op,
  output logic            addr_sel,
  output logic            mem_rd,
  output logic            mem_wr,
  output logic            halted,
  output logic [CNTW-1:0] instr_cnt
);

`ifdef PAPER_STEP_EN
  localparam state_e RETIRE_ST = ST_PAUSE;
`else
  localparam state_e RETIRE_ST = ST_FETCH;
`endif

  state_e     state_reg, state_next;
  logic [2:0] op_q_reg;
  logic [2:0] op_dec;
  logic       halted_reg;
  logic       retire;

  // Opcodes 8 and above carry nonzero upper bits and behave as NOP.
  assign op_dec = ((ir_op >> 3) == '0) ? ir_op[2:0] : OP_NOP;

  always_comb begin
    state_next = state_reg;
    retire     = 1'b0;
    pc_en      = 1'b0;
    pc_ld      = 1'b0;
    ir_en      = 1'b0;
    acc_en     = 1'b0;
    acc_sel    = 1'b0;
    alu_op     = ALU_PASS;
    addr_sel   = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    case (state_reg)
      ST_FETCH: begin
        mem_rd = 1'b1;
        if (mem_rdy) begin
          ir_en      = 1'b1;
          pc_en      = 1'b1;
          state_next = ST_DECODE;
        end
      end
      ST_DECODE: begin
        case (op_dec)
          OP_NOP:        begin state_next = RETIRE_ST; retire = 1'b1; end
          OP_HLT:        state_next = ST_HALT;
          OP_JMP, OP_JZ: state_next = ST_EXEC;
          default:       state_next = ST_MEM;
        endcase
      end
      ST_MEM: begin
        addr_sel = 1'b1;
        mem_wr   = (op_q_reg == OP_STA);
        mem_rd   = (op_q_reg != OP_STA);
        if (mem_rdy) begin
          if (op_q_reg == OP_STA) begin
            state_next = RETIRE_ST;
            retire     = 1'b1;
          end else begin
            state_next = ST_WB;
          end
        end
      end
      ST_WB: begin
        acc_en     = 1'b1;
        acc_sel    = (op_q_reg == OP_LDA);
        alu_op     = alu_for(op_q_reg);
        state_next = RETIRE_ST;
        retire     = 1'b1;
      end
      ST_EXEC: begin
        pc_ld      = (op_q_reg == OP_JMP) || acc_zero;
        state_next = RETIRE_ST;
        retire     = 1'b1;
      end
      ST_HALT: state_next = ST_HALT;
`ifdef PAPER_STEP_EN
      ST_PAUSE: if (step) state_next = ST_FETCH;
`endif
      default: state_next = ST_FETCH;
    endcase
    // Reset silences every strobe in the same cycle, even mid memory wait.
    if (rst) begin
      retire   = 1'b0;
      pc_en    = 1'b0;
      pc_ld    = 1'b0;
      ir_en    = 1'b0;
      acc_en   = 1'b0;
      acc_sel  = 1'b0;
      alu_op   = ALU_PASS;
      addr_sel = 1'b0;
      mem_rd   = 1'b0;
      mem_wr   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_FETCH;
      op_q_reg   <= OP_NOP;
      halted_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      halted_reg <= (state_next == ST_HALT);
      if (state_reg == ST_DECODE)
        op_q_reg <= op_dec;
    end
  end

  assign halted = halted_reg;

  paper_retire_cnt #(.CNTW(CNTW)) u_retire_cnt (
    .clk (clk),
    .rst (rst),
    .inc (retire),
    .cnt (instr_cnt)
  );

endmodule
